// File: rtl/id_operand_fwd_sb_if.sv
`default_nettype none
// ============================================================================
// Module  : id_operand_fwd_sb_if
// Brief   : Bus bundle for the ID operand-fetch / forwarding / scoreboard stage.
//           The statistics outputs exist only when ID_FWD_STAT_EN is defined.
// Revision: 1.0
// ============================================================================
interface id_operand_fwd_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NSRC   = 3
);
    localparam int AW = $clog2(NREG);

    logic                   id_valid;
    logic [NRD-1:0]         rd_en;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*DATA_W-1:0]  rf_rdata;
    logic [NSRC-1:0]        fwd_we;
    logic [NSRC*AW-1:0]     fwd_waddr;
    logic [NSRC*DATA_W-1:0] fwd_wdata;
    logic [NSRC-1:0]        fwd_dvalid;
    logic                   iss_load;
    logic [AW-1:0]          iss_waddr;
    logic                   ret_valid;
    logic [AW-1:0]          ret_waddr;
    logic                   ex_stall;
    logic                   stallreq;
    logic                   sb_full;
    logic                   out_valid;
    logic [NRD*DATA_W-1:0]  out_op;
`ifdef ID_FWD_STAT_EN
    logic [31:0]            stat_stall_cnt;
    logic [31:0]            stat_fwd_cnt;
`endif

    modport master (
        output id_valid, rd_en, rd_addr, rf_rdata,
        output fwd_we, fwd_waddr, fwd_wdata, fwd_dvalid,
        output iss_load, iss_waddr, ret_valid, ret_waddr, ex_stall,
`ifdef ID_FWD_STAT_EN
        input  stat_stall_cnt, stat_fwd_cnt,
`endif
        input  stallreq, sb_full, out_valid, out_op
    );

    modport slave (
        input  id_valid, rd_en, rd_addr, rf_rdata,
        input  fwd_we, fwd_waddr, fwd_wdata, fwd_dvalid,
        input  iss_load, iss_waddr, ret_valid, ret_waddr, ex_stall,
`ifdef ID_FWD_STAT_EN
        output stat_stall_cnt, stat_fwd_cnt,
`endif
        output stallreq, sb_full, out_valid, out_op
    );
endinterface
`default_nettype wire

// File: rtl/id_operand_fwd_sb.sv
`default_nettype none
// ============================================================================
// Module  : id_operand_fwd_sb
// Brief   : ID operand fetch with youngest-first forwarding, outstanding-load
//           scoreboard and ID/EX register. ID_FWD_STAT_EN adds stat counters.
// Revision: 1.0
// ============================================================================
module id_operand_fwd_sb #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NSRC    = 3,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    id_operand_fwd_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] c_max_out = CW'(MAX_OUT);

    logic [CW-1:0]         r_sb_cnt [NREG];
    logic [CW-1:0]         r_total;
    logic                  r_out_valid;
    logic [NRD*DATA_W-1:0] r_out_op;

    logic [NRD-1:0]        w_hazard;
    logic [NRD-1:0]        w_fwd_used;
    logic [NRD*DATA_W-1:0] w_op;
    logic [AW-1:0]         w_addr;
    logic                  w_found;
    logic                  w_found_dv;
    logic [DATA_W-1:0]     w_found_data;
    logic                  w_sb_full;
    logic                  w_stallreq;
    logic                  w_fire;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_same;

    // Sources are scanned oldest to youngest so the lowest matching index wins.
    always_comb begin : p_resolve
        w_hazard     = '0;
        w_fwd_used   = '0;
        w_op         = '0;
        w_addr       = '0;
        w_found      = 1'b0;
        w_found_dv   = 1'b0;
        w_found_data = '0;
        for (int i = 0; i < NRD; i++) begin
            w_addr       = bus.rd_addr[i*AW +: AW];
            w_found      = 1'b0;
            w_found_dv   = 1'b0;
            w_found_data = '0;
            for (int j = NSRC - 1; j >= 0; j--) begin
                if (bus.fwd_we[j] && (bus.fwd_waddr[j*AW +: AW] == w_addr)) begin
                    w_found      = 1'b1;
                    w_found_dv   = bus.fwd_dvalid[j];
                    w_found_data = bus.fwd_wdata[j*DATA_W +: DATA_W];
                end
            end
            if (bus.rd_en[i] && (w_addr != '0)) begin
                if (w_found) begin
                    if (w_found_dv) begin
                        w_op[i*DATA_W +: DATA_W] = w_found_data;
                        w_fwd_used[i]            = 1'b1;
                    end else begin
                        w_hazard[i] = 1'b1;
                    end
                end else if (r_sb_cnt[w_addr] != '0) begin
                    w_hazard[i] = 1'b1;
                end else begin
                    w_op[i*DATA_W +: DATA_W] = bus.rf_rdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_sb_full  = (r_total == c_max_out);
    assign w_stallreq = bus.id_valid && ((|w_hazard) || (bus.iss_load && w_sb_full));
    assign w_fire     = bus.id_valid && !w_stallreq && !bus.ex_stall;

    // An issue and a retire to the same register cancel, even from a zero count.
    assign w_same = w_fire && bus.iss_load && bus.ret_valid
                    && (bus.iss_waddr == bus.ret_waddr);
    assign w_inc  = w_fire && bus.iss_load && (bus.iss_waddr != '0) && !w_same;
    assign w_dec  = bus.ret_valid && (bus.ret_waddr != '0)
                    && (r_sb_cnt[bus.ret_waddr] != '0) && !w_same;

    always_ff @(posedge clk or posedge rst) begin : p_scoreboard
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_sb_cnt[r] <= '0;
            end
            r_total <= '0;
        end else begin
            if (w_inc) begin
                r_sb_cnt[bus.iss_waddr] <= r_sb_cnt[bus.iss_waddr] + 1'b1;
            end
            if (w_dec) begin
                r_sb_cnt[bus.ret_waddr] <= r_sb_cnt[bus.ret_waddr] - 1'b1;
            end
            r_total <= r_total + CW'(w_inc) - CW'(w_dec);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_id_ex
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
        end else if (!bus.ex_stall) begin
            r_out_valid <= w_fire;
            if (w_fire) begin
                r_out_op <= w_op;
            end
        end
    end

    assign bus.stallreq  = w_stallreq;
    assign bus.sb_full   = w_sb_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_out_op;

`ifdef ID_FWD_STAT_EN
    logic [31:0] r_stat_stall_cnt;
    logic [31:0] r_stat_fwd_cnt;
    logic [31:0] w_fwd_num;

    always_comb begin : p_fwd_num
        w_fwd_num = '0;
        for (int i = 0; i < NRD; i++) begin
            w_fwd_num = w_fwd_num + 32'(w_fwd_used[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_stat
        if (rst) begin
            r_stat_stall_cnt <= '0;
            r_stat_fwd_cnt   <= '0;
        end else begin
            if (w_stallreq) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
            if (w_fire) begin
                r_stat_fwd_cnt <= r_stat_fwd_cnt + w_fwd_num;
            end
        end
    end

    assign bus.stat_stall_cnt = r_stat_stall_cnt;
    assign bus.stat_fwd_cnt   = r_stat_fwd_cnt;
`endif
endmodule
`default_nettype wire
